spi_cmd_ram: RTL and testbench
==============================

SPI_CMD_RAM -- requirements
Module: spi_cmd_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8, address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  10  command word from the SPI slave; [9:8] opcode, [7:0] payload.
REQ-006 rx_valid  input  1  single-cycle strobe qualifying rx_data.
REQ-007 tx_data  output  8  read data returned to the SPI slave.
REQ-008 tx_valid  output  1  single-cycle strobe qualifying tx_data.
REQ-009 cmd_err  output  1  single-cycle strobe flagging a rejected command.

Function
REQ-010 Opcode 2'b00 (WR_ADDR) with rx_valid SHALL load wr_addr from rx_data[7:0] and set wa_vld.
REQ-011 Opcode 2'b01 (WR_DATA) with wa_vld=1 SHALL write rx_data[7:0] to mem[wr_addr]; with wa_vld=0 it SHALL leave memory unchanged and pulse cmd_err in the next cycle.
REQ-012 Opcode 2'b10 (RD_ADDR) SHALL load rd_addr from rx_data[7:0] and set ra_vld.
REQ-013 Opcode 2'b11 (RD_DATA) SHALL ignore rx_data[7:0] (dummy byte); with ra_vld=0 it SHALL pulse cmd_err in the next cycle and not issue a read.
REQ-014 Read FSM states: IDLE, READ, PRESENT; IDLE->READ on accepted RD_DATA, READ->PRESENT unconditionally, PRESENT->IDLE unconditionally.
REQ-015 READ SHALL register mem[rd_addr] into tx_data; PRESENT SHALL drive tx_valid=1 for exactly one cycle; tx_valid SHALL rise 2 cycles after the rx_valid cycle.
REQ-016 tx_data SHALL hold its value until the next read completes.
REQ-017 RD_DATA arriving while the FSM is not IDLE SHALL be dropped and SHALL pulse cmd_err.
REQ-018 WR_ADDR, WR_DATA, RD_ADDR SHALL be accepted in any FSM state; RD_ADDR during READ SHALL NOT alter the in-flight read (address captured at IDLE->READ).
REQ-019 WR_DATA to the address being read in the same cycle as READ SHALL return old data (read-before-write).
REQ-020 rx_valid=0 SHALL cause no state change apart from FSM progression.
REQ-021 wa_vld and ra_vld SHALL stay set until reset.

Reset
REQ-022 rst=1 SHALL immediately force tx_data=8'h00, tx_valid=0, cmd_err=0, FSM=IDLE, wr_addr=0, rd_addr=0, wa_vld=0, ra_vld=0.
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 Reset during READ or PRESENT SHALL abort the read; no tx_valid pulse SHALL follow release.
REQ-025 First rx_valid SHALL be honoured in the first clock edge after rst deasserts.

Configuration
REQ-026 Macro SPI_RAM_ADDR_AUTOINC_EN, when defined, SHALL increment wr_addr after each accepted WR_DATA and rd_addr at each IDLE->READ, both wrapping MEM_DEPTH-1 -> 0.
REQ-027 Without SPI_RAM_ADDR_AUTOINC_EN, wr_addr and rd_addr SHALL change only on WR_ADDR/RD_ADDR and reset.

Verification
REQ-028 WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_data=0xA5, tx_valid one cycle, 2 cycles after RD_DATA strobe.
REQ-029 After reset, WR_DATA 0x33 with no WR_ADDR -> cmd_err pulse, later read of address 0 returns pre-existing value.
REQ-030 RD_DATA, then RD_DATA on the next cycle -> second dropped, cmd_err pulse, single tx_valid.
REQ-031 rst asserted in READ cycle -> tx_valid never pulses, tx_data=0x00, memory retained.
REQ-032 AUTOINC defined: WR_ADDR 0xFF, WR_DATA 0x01, WR_DATA 0x02; RD_ADDR 0xFF, RD_DATA x2 -> tx_data 0x01 then 0x02 (wrap to 0x00).
REQ-033 AUTOINC undefined: same stimulus -> mem[0xFF]=0x02, both reads return 0x02.

Source files
------------

// File: rtl/spi_cmd_ram_if.sv
// Command/response bus between an SPI slave front end and spi_cmd_ram.
// The master drives 10-bit command words and receives read data and error strobes.
interface spi_cmd_ram_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cmd_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid,
    input  cmd_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid,
    output cmd_err
  );
endinterface

// File: rtl/spi_cmd_ram.sv
// SPI command decoder over an 8-bit RAM; SPI_RAM_ADDR_AUTOINC_EN enables address auto-increment.
// Read data strobes 2 cycles after RD_DATA; no backpressure, so overlapping or unarmed commands pulse cmd_err.
module spi_cmd_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input logic         clk,
  input logic         rst,
  spi_cmd_ram_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    PRESENT = 2'b10
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];
  state_t               state;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 wa_vld;
  logic                 ra_vld;

  logic [1:0]           opcode;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 wr_data_go;
  logic                 rd_data_cmd;
  logic                 rd_go;
  logic                 cmd_bad;

  assign opcode       = bus.rx_data[9:8];
  assign payload      = bus.rx_data[7:0];
  assign payload_addr = ADDR_SIZE'(payload);

  assign wr_data_go  = bus.rx_valid && (opcode == OP_WR_DATA) && wa_vld;
  assign rd_data_cmd = bus.rx_valid && (opcode == OP_RD_DATA);
  assign rd_go       = rd_data_cmd && ra_vld && (state == IDLE);
  assign cmd_bad     = (bus.rx_valid && (opcode == OP_WR_DATA) && !wa_vld) ||
                       (rd_data_cmd && !rd_go);

  // Memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_data_go) begin
      mem[wr_addr] <= payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_addr      <= '0;
      rd_addr      <= '0;
      rd_ptr       <= '0;
      wa_vld       <= 1'b0;
      ra_vld       <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
      bus.cmd_err  <= 1'b0;
    end else begin
      bus.cmd_err <= cmd_bad;

      if (bus.rx_valid) begin
        case (opcode)
          OP_WR_ADDR: begin
            wr_addr <= payload_addr;
            wa_vld  <= 1'b1;
          end
          OP_WR_DATA: begin
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            if (wa_vld) begin
              wr_addr <= wr_addr + ADDR_SIZE'(1);
            end
`endif
          end
          OP_RD_ADDR: begin
            rd_addr <= payload_addr;
            ra_vld  <= 1'b1;
          end
          default: ;
        endcase
      end

      // rd_ptr freezes the address at launch so later RD_ADDR cannot disturb the read.
      case (state)
        IDLE: begin
          bus.tx_valid <= 1'b0;
          if (rd_go) begin
            rd_ptr <= rd_addr;
            state  <= READ;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            rd_addr <= rd_addr + ADDR_SIZE'(1);
`endif
          end
        end
        READ: begin
          bus.tx_data  <= mem[rd_ptr];
          bus.tx_valid <= 1'b1;
          state        <= PRESENT;
        end
        PRESENT: begin
          bus.tx_valid <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          bus.tx_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Scoreboard bench for spi_cmd_ram; expected read bytes are queued at RD_DATA and popped on tx_valid.
// Honours SPI_RAM_ADDR_AUTOINC_EN when the same macro is defined for the build.
module tb_spi_cmd_ram;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] WD = 2'b01;
  localparam logic [1:0] RA = 2'b10;
  localparam logic [1:0] RD = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_q [$];

  spi_cmd_ram_if bus ();

  spi_cmd_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every tx_valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.tx_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: tx_valid with tx_data=%02h, no read expected", bus.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          errors++;
          $display("FAIL sb_data: tx_data=%02h expected %02h", bus.tx_data, e);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    bus.rx_data  = {op, pl};
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks++;
    if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b0 || bus.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx_data=%02h tx_valid=%b cmd_err=%b expected 00 0 0",
               bus.tx_data, bus.tx_valid, bus.cmd_err);
    end
    // First command right at release must be taken, otherwise WR_DATA below errors.
    rst = 1'b0;
    send(WA, 8'h00);
    send(WD, 8'h5C);
    checks++;
    if (bus.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL first_cmd_after_reset: cmd_err=%b expected 0", bus.cmd_err);
    end
    idle(2);
  endtask

  task automatic test_basic;
    send(WA, 8'h10);
    send(WD, 8'hA5);
    send(RA, 8'h10);
    exp_q.push_back(8'hA5);
    send(RD, 8'h77);
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat1: tx_valid=%b expected 0 one cycle after RD_DATA", bus.tx_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_lat2: tx_valid=%b tx_data=%02h expected 1 a5", bus.tx_valid, bus.tx_data);
    end
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_single: tx_valid=%b expected 0 after one cycle", bus.tx_valid);
    end
    idle(4);
    checks++;
    if (bus.tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_hold: tx_data=%02h expected a5", bus.tx_data);
    end
  endtask

  task automatic test_wr_no_addr;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checks++;
    if (bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_txdata: tx_data=%02h expected 00", bus.tx_data);
    end
    send(WD, 8'h33);
    checks++;
    if (bus.cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_no_addr_err: cmd_err=%b expected 1", bus.cmd_err);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_addr_pulse: cmd_err=%b expected 0", bus.cmd_err);
    end
    send(RD, 8'h00);
    checks++;
    if (bus.cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL rd_no_addr_err: cmd_err=%b expected 1", bus.cmd_err);
    end
    idle(4);
    send(RA, 8'h00);
    exp_q.push_back(8'h5C);
    send(RD, 8'h00);
    idle(4);
  endtask

  task automatic test_back_to_back;
    send(RA, 8'h10);
    exp_q.push_back(8'hA5);
    send(RD, 8'h00);
    send(RD, 8'h00);
    checks++;
    if (bus.cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drop_err: cmd_err=%b expected 1", bus.cmd_err);
    end
    idle(5);
    // RD_ADDR landing during READ must not redirect the in-flight read.
    send(RA, 8'h10);
    exp_q.push_back(8'hA5);
    send(RD, 8'h00);
    send(RA, 8'h00);
    idle(4);
    // WR_DATA in the READ cycle to the same address returns old data.
    send(WA, 8'h20);
    send(WD, 8'h11);
    send(RA, 8'h20);
    send(WA, 8'h20);
    exp_q.push_back(8'h11);
    send(RD, 8'h00);
    send(WD, 8'h22);
    idle(4);
    send(RA, 8'h20);
    exp_q.push_back(8'h22);
    send(RD, 8'h00);
    idle(4);
  endtask

  task automatic test_reset_abort;
    send(RA, 8'h10);
    send(RD, 8'h00);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: tx_data=%02h tx_valid=%b expected 00 0", bus.tx_data, bus.tx_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    checks++;
    if (bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_txdata: tx_data=%02h expected 00", bus.tx_data);
    end
    send(RA, 8'h10);
    exp_q.push_back(8'hA5);
    send(RD, 8'h00);
    idle(4);
  endtask

  task automatic test_autoinc;
    send(WA, 8'hFF);
    send(WD, 8'h01);
    send(WD, 8'h02);
    send(RA, 8'hFF);
`ifdef SPI_RAM_ADDR_AUTOINC_EN
    exp_q.push_back(8'h01);
`else
    exp_q.push_back(8'h02);
`endif
    send(RD, 8'h00);
    idle(3);
    exp_q.push_back(8'h02);
    send(RD, 8'h00);
    idle(4);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    test_reset();
    test_basic();
    test_wr_no_addr();
    test_back_to_back();
    test_reset_abort();
    test_autoinc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected reads never arrived, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
